// File: rtl/sram_like_resp.sv
// SRAM-like slave: 2-entry in-order request queue in front of a word memory, fixed response latency.
// Optional SRAM_LIKE_RANDOM_DELAY_EN adds LFSR-driven accept stalls and extra response delay.
module sram_like_resp #(
  parameter int LATENCY    = 2,
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  typedef struct packed {
    logic                  wr;
    logic [3:0]            wstrb;
    logic [ADDR_WIDTH-1:0] idx;
    logic [31:0]           wdata;
  } entry_t;

  localparam logic [4:0] BASE_CNT = 5'(LATENCY - 1);

  logic [31:0] mem [2**ADDR_WIDTH];
  entry_t      q [2];
  entry_t      head;
  logic        head_ptr;
  logic        tail_ptr;
  logic [1:0]  count;
  logic [4:0]  cnt;
  logic [4:0]  cnt_load;
  logic        push;
  logic        pop;
  logic        unused_bits;

  // Size and the aliased address bits carry no meaning for a word-wide memory.
  assign unused_bits = ^{size, addr[31:ADDR_WIDTH+2], addr[1:0]};

`ifdef SRAM_LIKE_RANDOM_DELAY_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign addr_ok  = (count < 2'd2) && !reset && lfsr[0];
  assign cnt_load = BASE_CNT + {3'b000, lfsr[2:1]};
`else
  assign addr_ok  = (count < 2'd2) && !reset;
  assign cnt_load = BASE_CNT;
`endif

  assign head = q[head_ptr];
  assign push = req && addr_ok;
  assign pop  = (count != 2'd0) && (cnt == 5'd0);

  // Queue bookkeeping; cnt always belongs to whichever entry is currently at the head.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= 2'd0;
      head_ptr <= 1'b0;
      tail_ptr <= 1'b0;
      cnt      <= 5'd0;
      data_ok  <= 1'b0;
      rdata    <= 32'h0;
    end else begin
      data_ok <= pop;
      if (pop && !head.wr) begin
        rdata <= mem[head.idx];
      end
      if (pop) begin
        head_ptr <= ~head_ptr;
      end
      if (push) begin
        tail_ptr <= ~tail_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
      if ((pop && count == 2'd2) || (push && count == 2'd0) ||
          (push && pop && count == 2'd1)) begin
        cnt <= cnt_load;
      end else if (cnt != 5'd0) begin
        cnt <= cnt - 5'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q[tail_ptr] <= '{wr: wr, wstrb: wstrb, idx: addr[ADDR_WIDTH+1:2], wdata: wdata};
    end
  end

  // Memory is deliberately left out of reset so contents survive a reset.
  always_ff @(posedge clk) begin
    if (pop && head.wr) begin
      for (int b = 0; b < 4; b++) begin
        if (head.wstrb[b]) begin
          mem[head.idx][8*b +: 8] <= head.wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_like_resp.sv
// Self-checking bench for sram_like_resp: table vectors plus scoreboard on a LATENCY=2 instance,
// and a hand sequence on a LATENCY=1 instance.
module tb_sram_like_resp;

  localparam int LAT = 2;

  typedef struct {
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    int          gap;
  } vec_t;

  typedef struct {
    int          acc;
    int          dok;
    logic        wr;
    logic [3:0]  wstrb;
    logic [9:0]  idx;
    logic [31:0] wdata;
    logic [31:0] exp;
    bit          use_exp;
  } sb_t;

  logic        clk;
  logic        reset;
  logic        req, wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;

  logic        req1, wr1;
  logic [3:0]  wstrb1;
  logic [31:0] addr1, wdata1;
  logic        addr_ok1, data_ok1;
  logic [31:0] rdata1;

  int          vectors;
  int          miscompares;
  int          cycle;
  int          accept_count;
  int          last_dok;
  logic [31:0] last_read;
  logic [31:0] cur_exp;
  bit          cur_use;
  logic [31:0] model [1024];
  sb_t         sb [$];
  vec_t        vecs [14];
  logic [31:0] l1_vals [3];
  int          occ;
  sb_t         e;
  logic [31:0] expv;

  sram_like_resp #(.LATENCY(LAT), .ADDR_WIDTH(10)) dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
  );

  sram_like_resp #(.LATENCY(1), .ADDR_WIDTH(10)) dut1 (
    .clk(clk), .reset(reset), .req(req1), .wr(wr1), .size(2'd2), .wstrb(wstrb1),
    .addr(addr1), .wdata(wdata1), .addr_ok(addr_ok1), .data_ok(data_ok1), .rdata(rdata1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Scoreboard monitor for the LATENCY=2 instance: predicts addr_ok, retire cycle and rdata.
  always @(negedge clk) begin
    if (reset) begin
      checkOutput("reset addr_ok", {31'b0, addr_ok}, 32'd0);
      checkOutput("reset data_ok", {31'b0, data_ok}, 32'd0);
      checkOutput("reset rdata", rdata, 32'h0);
      sb.delete();
      last_read = 32'h0;
      last_dok = 0;
    end else begin
      occ = 0;
      foreach (sb[i]) if (sb[i].acc < cycle && sb[i].dok > cycle) occ++;
      checkOutput("addr_ok", {31'b0, addr_ok}, {31'b0, occ < 2});
      if (sb.size() > 0 && sb[0].dok < cycle) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL missing data_ok: got none, expected pulse at cycle %0d", sb[0].dok);
        void'(sb.pop_front());
      end
      if (data_ok) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL spurious data_ok: got 1, expected 0 (cycle %0d)", cycle);
        end else begin
          e = sb.pop_front();
          checkOutput("data_ok cycle", cycle, e.dok);
          if (e.wr) begin
            expv = last_read;
            for (int b = 0; b < 4; b++)
              if (e.wstrb[b]) model[e.idx][8*b +: 8] = e.wdata[8*b +: 8];
          end else begin
            expv = model[e.idx];
          end
          if (e.use_exp) expv = e.exp;
          checkOutput(e.wr ? "write keeps rdata" : "read rdata", rdata, expv);
          if (!e.wr) last_read = expv;
        end
      end
      if (req && addr_ok) begin
        e.acc     = cycle;
        e.dok     = ((cycle + 1 > last_dok) ? cycle + 1 : last_dok) + LAT;
        e.wr      = wr;
        e.wstrb   = wstrb;
        e.idx     = addr[11:2];
        e.wdata   = wdata;
        e.exp     = cur_exp;
        e.use_exp = cur_use;
        last_dok  = e.dok;
        sb.push_back(e);
        accept_count++;
      end
    end
  end

  task automatic idle(input int n);
    req = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called just after a rising edge; returns just after the edge ending the accepting cycle.
  task automatic applyStimulus(input logic w, input logic [3:0] s, input logic [31:0] a,
                               input logic [31:0] d, input logic [31:0] x, input bit use_exp);
    int  n;
    bit  done;
    n       = accept_count;
    done    = 1'b0;
    req     = 1'b1;
    wr      = w;
    wstrb   = s;
    addr    = a;
    wdata   = d;
    cur_exp = x;
    cur_use = use_exp;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (accept_count != n) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL accept timeout: got no addr_ok, expected acceptance of addr %h", a);
      req = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] r;
    logic [9:0]  ridx;
    vectors = 0;
    miscompares = 0;
    accept_count = 0;
    last_dok = 0;
    last_read = 32'h0;
    cur_exp = 32'h0;
    cur_use = 1'b0;
    reset = 1'b1;
    req = 1'b0; wr = 1'b0; size = 2'd2; wstrb = 4'h0; addr = 32'h0; wdata = 32'h0;
    req1 = 1'b0; wr1 = 1'b0; wstrb1 = 4'h0; addr1 = 32'h0; wdata1 = 32'h0;

    vecs[0]  = '{1'b1, 4'hF,    32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 4};
    vecs[1]  = '{1'b0, 4'h0,    32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 4};
    vecs[2]  = '{1'b1, 4'b0010, 32'h0000_0010, 32'h0000_AA00, 32'hDEAD_BEEF, 0};
    vecs[3]  = '{1'b0, 4'h0,    32'h0000_0010, 32'h0,         32'hDEAD_AAEF, 0};
    vecs[4]  = '{1'b1, 4'b1100, 32'h0000_1010, 32'h1234_5678, 32'hDEAD_AAEF, 0};
    vecs[5]  = '{1'b0, 4'h0,    32'hFFFF_F013, 32'h0,         32'h1234_AAEF, 0};
    vecs[6]  = '{1'b1, 4'hF,    32'h0000_0020, 32'hCAFE_F00D, 32'h1234_AAEF, 0};
    vecs[7]  = '{1'b0, 4'h0,    32'h0000_0020, 32'h0,         32'hCAFE_F00D, 0};
    vecs[8]  = '{1'b1, 4'hF,    32'h0000_0024, 32'hA5A5_A5A5, 32'hCAFE_F00D, 0};
    vecs[9]  = '{1'b1, 4'b0100, 32'h0000_0024, 32'h0077_0000, 32'hCAFE_F00D, 0};
    vecs[10] = '{1'b0, 4'h0,    32'h0000_0024, 32'h0,         32'hA577_A5A5, 4};
    vecs[11] = '{1'b0, 4'h0,    32'h0000_0010, 32'h0,         32'h1234_AAEF, 0};
    vecs[12] = '{1'b0, 4'h0,    32'h0000_0020, 32'h0,         32'hCAFE_F00D, 0};
    vecs[13] = '{1'b0, 4'h0,    32'h0000_0024, 32'h0,         32'hA577_A5A5, 6};
    l1_vals[0] = 32'h0101_0101;
    l1_vals[1] = 32'h0202_0202;
    l1_vals[2] = 32'h0303_0303;

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(2);

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].wr, vecs[i].wstrb, vecs[i].addr, vecs[i].wdata, vecs[i].exp, 1'b1);
      if (vecs[i].gap > 0) idle(vecs[i].gap);
    end

    for (int i = 0; i < 8; i++)
      applyStimulus(1'b1, 4'hF, 32'h100 + 32'(4 * i), 32'hA0A0_0000 + 32'(i), 32'h0, 1'b0);
    idle(8);

    // Two writes still queued when reset hits: neither may reach memory.
    applyStimulus(1'b1, 4'hF, 32'h100, 32'h1111_1111, 32'h0, 1'b0);
    applyStimulus(1'b1, 4'hF, 32'h104, 32'h2222_2222, 32'h0, 1'b0);
    req = 1'b0;
    reset = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    idle(2);
    applyStimulus(1'b0, 4'h0, 32'h100, 32'h0, 32'hA0A0_0000, 1'b1);
    idle(6);
    applyStimulus(1'b0, 4'h0, 32'h104, 32'h0, 32'hA0A0_0001, 1'b1);
    idle(6);

    for (int i = 0; i < 300; i++) begin
      r = $urandom();
      ridx = 10'h40 + 10'($urandom_range(0, 7));
      applyStimulus(r[4], r[11:8], {r[31:12], ridx, r[1:0]}, $urandom(), 32'h0, 1'b0);
      idle($urandom_range(0, 2));
    end
    idle(20);
    checkOutput("scoreboard drained", sb.size(), 32'd0);

    // LATENCY=1 instance: preload three words, then back-to-back reads.
    for (int k = 0; k < 3; k++) begin
      req1 = 1'b1; wr1 = 1'b1; wstrb1 = 4'hF; addr1 = 32'(4 * k); wdata1 = l1_vals[k];
      @(negedge clk);
      checkOutput("lat1 write addr_ok", {31'b0, addr_ok1}, 32'd1);
      @(posedge clk);
      #1;
    end
    req1 = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    for (int k = 0; k < 7; k++) begin
      if (k < 3) begin
        req1 = 1'b1; wr1 = 1'b0; addr1 = 32'(4 * k);
      end else begin
        req1 = 1'b0;
      end
      @(negedge clk);
      if (k < 3) checkOutput("lat1 read addr_ok", {31'b0, addr_ok1}, 32'd1);
      checkOutput("lat1 data_ok", {31'b0, data_ok1}, {31'b0, (k >= 2 && k <= 4)});
      if (k >= 2 && k <= 4) checkOutput("lat1 rdata", rdata1, l1_vals[k-2]);
      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
